// File: rtl/serializer_pkg.sv
// Shared types for the PISO serializer: FSM state enum and default word width.
// Build option: define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
package serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;
`endif

endpackage

// File: rtl/piso_shift_core.sv
// Shift register and bit counter for the PISO serializer; shifts left, MSB out first.
// WIDTH must be at least 2.
module piso_shift_core
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_msb,
  output logic             q_next,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_count;

  // Load wins over shift; zero fills the LSB as bits leave the MSB.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shreg <= '0;
      r_count <= '0;
    end else if (load) begin
      r_shreg <= d;
      r_count <= '0;
    end else if (shift) begin
      r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign q_msb  = r_shreg[WIDTH-1];
  assign q_next = r_shreg[WIDTH-2];
  assign count  = r_count;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready input and stallable serial output.
// Build option: define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  ser_state_t       r_state;
  ser_state_t       w_next_state;
  logic             r_din_ready;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_done;
  logic             w_din_ready;
  logic             w_sout;
  logic             w_sout_valid;
  logic             w_done;
  logic             w_load;
  logic             w_shift;
  logic             w_q_msb;
  logic             w_q_next;
  logic             w_last;
  logic [CNT_W-1:0] w_count;

  piso_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (w_load),
    .shift   (w_shift),
    .d       (din),
    .q_msb   (w_q_msb),
    .q_next  (w_q_next),
    .count   (w_count)
  );

  assign w_last = (w_count == CNT_W'(WIDTH - 1));

`ifdef SERIALIZER_PARITY_EN
  logic r_parity;

  // Parity is taken from the word at capture time since the shifter discards bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= ^din;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_din_ready  <= 1'b1;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_din_ready  <= w_din_ready;
      r_sout       <= w_sout;
      r_sout_valid <= w_sout_valid;
      r_done       <= w_done;
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_sout       = 1'b0;
    w_sout_valid = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (din_valid) begin
          w_load       = 1'b1;
          w_next_state = SHIFT;
          w_sout       = din[WIDTH-1];
          w_sout_valid = 1'b1;
        end
      end
      SHIFT: begin
        w_sout       = w_q_msb;
        w_sout_valid = 1'b1;
        if (shift_en) begin
          w_shift = 1'b1;
          if (w_last) begin
`ifdef SERIALIZER_PARITY_EN
            w_next_state = PARITY;
            w_sout       = r_parity;
`else
            w_next_state = IDLE;
            w_sout       = 1'b0;
            w_sout_valid = 1'b0;
            w_done       = 1'b1;
`endif
          end else begin
            w_sout = w_q_next;
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        w_sout       = r_parity;
        w_sout_valid = 1'b1;
        if (shift_en) begin
          w_next_state = IDLE;
          w_sout       = 1'b0;
          w_sout_valid = 1'b0;
          w_done       = 1'b1;
        end
      end
`endif
      default: w_next_state = IDLE;
    endcase
    w_din_ready = (w_next_state == IDLE);
  end

  assign din_ready  = r_din_ready;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign done       = r_done;

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, default 4, parallel word width in bits.
REQ-002 clock  input  1  rising-edge clock; the block's only clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 din  input  WIDTH  parallel word from the upstream buffer register.
REQ-005 din_valid  input  1  din holds a word to transfer.
REQ-006 din_ready  output  1  block can accept a word this cycle.
REQ-007 shift_en  input  1  downstream consumes the current serial bit this cycle; 0 = stall.
REQ-008 sout  output  1  serial data bit, MSB first.
REQ-009 sout_valid  output  1  sout carries a frame bit.
REQ-010 done  output  1  one-cycle pulse after the last frame bit is consumed.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and PARITY; PARITY exists only with PARITY_EN.
REQ-012 din_ready SHALL be 1 in IDLE and 0 in every other state.
REQ-013 Acceptance SHALL occur on a rising edge where din_valid=1 and din_ready=1; din is captured into the shift register and the FSM enters SHIFT.
REQ-014 While din_ready=0, din and din_valid SHALL be ignored.
REQ-015 The first bit (din[WIDTH-1]) SHALL be on sout with sout_valid=1 in the cycle after acceptance (latency 1).
REQ-016 In SHIFT, on an edge with shift_en=1, the register SHALL shift left one bit, with 0 shifted in at the LSB, and the bit counter SHALL increment; with shift_en=0, sout, sout_valid and the counter SHALL hold.
REQ-017 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL reset to 0 on acceptance.
REQ-018 When the counter equals WIDTH-1 and shift_en=1, the FSM SHALL go to PARITY if PARITY_EN is defined, otherwise to IDLE.
REQ-019 In PARITY, sout SHALL equal the even-parity bit (XOR of the captured word) with sout_valid=1; the FSM SHALL exit to IDLE on shift_en=1.
REQ-020 done SHALL be 1 for exactly one cycle: the cycle after the edge that consumed the final frame bit (the cycle the FSM is back in IDLE).
REQ-021 In IDLE, sout and sout_valid SHALL be 0.
REQ-022 Back-to-back words SHALL be separated by at least one IDLE cycle; a word presented during a frame SHALL wait, not be dropped.
REQ-023 sout_valid SHALL NOT drop mid-frame, including during shift_en stalls of any length.

Reset
REQ-024 On reset_n=0, outputs SHALL take these values immediately: sout=0, sout_valid=0, done=0, din_ready=1. The FSM SHALL go to IDLE and the counter and shift register SHALL clear.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no done pulse; after release, the next accepted word starts a fresh frame.
REQ-026 Reset release SHALL be synchronous to clock in the integrating system; the block SHALL take no action on the release edge itself beyond leaving reset.

Configuration
REQ-027 Macro PIS0_SERIALIZER_PARITY_EN SHALL NOT be used; the macro SHALL be named SERIALIZER_PARITY_EN.
REQ-028 With SERIALIZER_PARITY_EN defined, each frame SHALL be WIDTH+1 bits (data then even parity).
REQ-029 Without SERIALIZER_PARITY_EN, each frame SHALL be WIDTH bits, the PARITY state and parity logic SHALL be absent, and the FSM SHALL be two-state.

Structure
REQ-030 Package serializer_pkg SHALL hold the state enum typedef (ser_state_t) and the default WIDTH constant.
REQ-031 The shift register and bit counter SHALL be one sub-module, piso_shift_core (load, shift, q_msb, count); the FSM and handshake SHALL live in the top.

Verification
REQ-032 Reset then din=4'b1101, din_valid=1, shift_en=1 throughout -> sout=1,1,0,1 on 4 consecutive cycles, sout_valid high for those cycles, then done pulse, din_ready back to 1.
REQ-033 din=4'b1101 with SERIALIZER_PARITY_EN -> sout=1,1,0,1,1 (parity=1), done after the fifth bit.
REQ-034 din=4'b1010 with shift_en held 0 for 3 cycles after the second bit -> sout holds 0 with sout_valid=1 for those cycles; the full sequence 1,0,1,0 is still delivered.
REQ-035 din_valid held high with words 4'b0011 then 4'b1100 -> both frames delivered intact, at least one IDLE cycle (din_ready=1) between them.
REQ-036 reset_n pulsed low after the second bit of 4'b1111 -> outputs clear immediately, no done pulse; the next word 4'b0001 serialises as 0,0,0,1.
